// File: rtl/bip_uart_report_if.sv
// rtl/bip_uart_report_if.sv - halt/result inputs and UART status outputs of the BIP result reporter
interface bip_uart_report_if #(
  parameter int NB_ADDR   = 11,
  parameter int RAM_WIDTH = 16
);
  logic                 i_halt;
  logic [NB_ADDR-1:0]   i_counter;
  logic [RAM_WIDTH-1:0] i_acc;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_halt, i_counter, i_acc,
    input  o_tx, o_busy, o_done
  );

  modport slave (
    input  i_halt, i_counter, i_acc,
    output o_tx, o_busy, o_done
  );
endinterface

// File: rtl/bip_uart_report.sv
// rtl/bip_uart_report.sv - on CPU halt, sends cycle count and accumulator once as an 8N1 UART frame
// Optional trailing XOR checksum byte is enabled by defining BIP_REPORT_CHKSUM_EN.
module bip_uart_report #(
  parameter int NB_ADDR   = 11,
  parameter int RAM_WIDTH = 16,
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input logic               i_clk,
  input logic               i_rst,
  bip_uart_report_if.slave  bus
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
`ifdef BIP_REPORT_CHKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic                 halt_q;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [2:0]           byte_idx;
  logic [15:0]          cnt_lat;
  logic [15:0]          acc_lat;
  logic [NB_ADDR-1:0]   counter_in;
  logic [RAM_WIDTH-1:0] acc_in;
  logic [15:0]          cnt_ext;
  logic [15:0]          acc_ext;
  logic [7:0]           cur_byte;
  logic                 trigger;
  logic                 baud_wrap;
  logic                 tx_next;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 done_reg;
`ifdef BIP_REPORT_CHKSUM_EN
  logic [7:0]           chk_lat;
`endif

  assign counter_in = bus.i_counter;
  assign acc_in     = bus.i_acc;
  assign cnt_ext    = 16'(counter_in);
  assign acc_ext    = 16'(acc_in);

  assign bus.o_tx   = tx_reg;
  assign bus.o_busy = busy_reg;
  assign bus.o_done = done_reg;

  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      3'd1:    cur_byte = cnt_lat[15:8];
      3'd2:    cur_byte = cnt_lat[7:0];
      3'd3:    cur_byte = acc_lat[15:8];
      3'd4:    cur_byte = acc_lat[7:0];
`ifdef BIP_REPORT_CHKSUM_EN
      3'd5:    cur_byte = chk_lat;
`endif
      default: cur_byte = 8'hA5;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // tx_next describes the current bit; registering it keeps o_tx glitch-free at a one-cycle lag
  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    tx_next    = 1'b1;
    baud_wrap  = (baud_cnt == BAUD_LAST);
    case (state)
      IDLE: begin
        if (bus.i_halt && !halt_q && !done_reg) begin
          trigger    = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_wrap) state_next = DATA;
      end
      DATA: begin
        tx_next = cur_byte[bit_idx];
        if (baud_wrap && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (baud_wrap) state_next = (byte_idx == LAST_BYTE) ? DONE : START;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt_q   <= 1'b0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      cnt_lat  <= 16'd0;
      acc_lat  <= 16'd0;
`ifdef BIP_REPORT_CHKSUM_EN
      chk_lat  <= 8'd0;
`endif
    end else begin
      halt_q <= bus.i_halt;
      tx_reg <= tx_next;
      if (trigger) begin
        cnt_lat  <= cnt_ext;
        acc_lat  <= acc_ext;
        busy_reg <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= 3'd0;
        byte_idx <= 3'd0;
`ifdef BIP_REPORT_CHKSUM_EN
        chk_lat  <= 8'hA5 ^ cnt_ext[15:8] ^ cnt_ext[7:0] ^ acc_ext[15:8] ^ acc_ext[7:0];
`endif
      end else if (state inside {START, DATA, STOP}) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + CW'(1);
        if (baud_wrap && (state == DATA)) bit_idx <= bit_idx + 3'd1;
        if (baud_wrap && (state == STOP) && (byte_idx != LAST_BYTE)) byte_idx <= byte_idx + 3'd1;
      end
      if ((state_next == DONE) && (state != DONE)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bip_uart_report.sv
// tb/tb_bip_uart_report.sv - bench for bip_uart_report: UART decoder monitor against an expected-byte queue
module tb_bip_uart_report;
  localparam int DIV = 10;
`ifdef BIP_REPORT_CHKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   rx_count = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [10:0] counter;
    logic [15:0] acc;
    int          busy_len;
  } vec_t;

  bip_uart_report_if #(.NB_ADDR(11), .RAM_WIDTH(16)) bus ();

  bip_uart_report #(
    .NB_ADDR(11), .RAM_WIDTH(16), .CLK_FREQ(100), .BAUD_RATE(10)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_frame(input logic [10:0] counter, input logic [15:0] acc);
    logic [15:0] c16;
    logic [7:0]  x;
    c16 = {5'd0, counter};
    x = 8'hA5 ^ c16[15:8] ^ c16[7:0] ^ acc[15:8] ^ acc[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(c16[15:8]);
    exp_q.push_back(c16[7:0]);
    exp_q.push_back(acc[15:8]);
    exp_q.push_back(acc[7:0]);
    if (NBYTES == 6) exp_q.push_back(x);
  endtask

  task automatic do_reset(input logic halt_val);
    @(negedge clk);
    rst = 1'b1;
    bus.i_halt = halt_val;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic trigger_frame(input string tag);
    @(negedge clk);
    bus.i_halt = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_rise"}, 32'(bus.o_busy), 32'd1);
    chk({tag, "_tx_high_1st_edge"}, 32'(bus.o_tx), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_tx_low_2nd_edge"}, 32'(bus.o_tx), 32'd0);
  endtask

  // Called just after the 2nd edge; the busy sample after the trigger edge is already known high.
  task automatic finish_frame(input string tag, input int exp_len);
    int n;
    bit ended;
    n = 1;
    ended = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_busy) n++;
      else begin
        ended = 1'b1;
        break;
      end
    end
    chk({tag, "_frame_ended"}, 32'(ended), 32'd1);
    chk({tag, "_busy_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
    repeat (20) @(negedge clk);
    chk({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // UART decoder: samples every clock of each bit so a wrong bit width shows up as an unstable bit
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit bad;
    bit abort;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_tx === 1'b0) begin
        bits = '1;
        bad = 1'b0;
        abort = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < DIV; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (rst) begin
              abort = 1'b1;
              break;
            end
            if (k == 0) bits[b] = bus.o_tx;
            else if (bus.o_tx !== bits[b]) bad = 1'b1;
          end
          if (abort) break;
        end
        if (!abort) begin
          rx_count++;
          chk("bit_width_stable", 32'(bad), 32'd0);
          chk("stop_bit", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(bits[8:1]), 32'h100);
          end else begin
            exp_b = exp_q.pop_front();
            chk("frame_byte", 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin : main
    vec_t vecs[4];
    int bad_idle;
    int rx_before;

    vecs[0] = '{counter: 11'h123, acc: 16'hBEEF, busy_len: NBYTES * 10 * DIV};
    vecs[1] = '{counter: 11'h7FF, acc: 16'hFFFF, busy_len: NBYTES * 10 * DIV};
    vecs[2] = '{counter: 11'h000, acc: 16'h0000, busy_len: NBYTES * 10 * DIV};
    vecs[3] = '{counter: 11'h400, acc: 16'h8001, busy_len: NBYTES * 10 * DIV};

    bus.i_halt = 1'b0;
    bus.i_counter = '0;
    bus.i_acc = '0;

    do_reset(1'b0);
    @(negedge clk);
    chk("reset_tx", 32'(bus.o_tx), 32'd1);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_done", 32'(bus.o_done), 32'd0);
    bad_idle = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) bad_idle++;
    end
    chk("idle_quiet", 32'(bad_idle), 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_reset(1'b0);
      bus.i_counter = vecs[i].counter;
      bus.i_acc = vecs[i].acc;
      push_frame(vecs[i].counter, vecs[i].acc);
      trigger_frame($sformatf("vec%0d", i));
      finish_frame($sformatf("vec%0d", i), vecs[i].busy_len);
    end

    // halt pulses during and after the frame, accumulator cleared mid-frame
    do_reset(1'b0);
    bus.i_counter = 11'h123;
    bus.i_acc = 16'hBEEF;
    rx_before = rx_count;
    push_frame(11'h123, 16'hBEEF);
    trigger_frame("pulse");
    fork
      finish_frame("pulse", NBYTES * 10 * DIV);
      begin
        repeat (3) begin
          repeat (40) @(negedge clk);
          bus.i_halt = 1'b0;
          repeat (3) @(negedge clk);
          bus.i_halt = 1'b1;
        end
        repeat (20) @(negedge clk);
        bus.i_acc = 16'h0000;
      end
    join
    bus.i_halt = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_halt = 1'b1;
    repeat (300) @(negedge clk);
    chk("pulse_one_frame", 32'(rx_count - rx_before), 32'(NBYTES));
    chk("pulse_busy_after", 32'(bus.o_busy), 32'd0);
    chk("pulse_done_sticky", 32'(bus.o_done), 32'd1);

    // reset in the middle of a frame, then a fresh frame
    do_reset(1'b0);
    bus.i_acc = 16'hBEEF;
    rx_before = rx_count;
    push_frame(11'h123, 16'hBEEF);
    trigger_frame("midrst");
    repeat (228) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(bus.o_tx), 32'd1);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    bus.i_halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_partial_bytes", 32'(rx_count - rx_before), 32'd2);
    exp_q.delete();
    rst = 1'b0;
    bus.i_counter = 11'h055;
    bus.i_acc = 16'h1234;
    push_frame(11'h055, 16'h1234);
    trigger_frame("afterrst");
    finish_frame("afterrst", NBYTES * 10 * DIV);

    // halt already high when reset releases counts as a rising edge
    @(negedge clk);
    rst = 1'b1;
    bus.i_halt = 1'b1;
    bus.i_counter = 11'h3A9;
    bus.i_acc = 16'hC0DE;
    repeat (3) @(negedge clk);
    exp_q.delete();
    push_frame(11'h3A9, 16'hC0DE);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("haltrst_busy_rise", 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1;
    chk("haltrst_tx_low", 32'(bus.o_tx), 32'd0);
    finish_frame("haltrst", NBYTES * 10 * DIV);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
